// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage.
//  - base opcodes and OP funct7 values
//  - ALU, secondary ALU (M extension) and writeback encodings
//  - immediate format enum
//  - decode_ctrl_t control bundle carried through the queue, and its width CTRL_W
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Primary ALU op follows the base funct3 numbering; alt_op selects SUB/SRA.
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    // Secondary ALU op follows the M-extension funct3 numbering.
    localparam logic [2:0] ALU2_MUL    = 3'd0;
    localparam logic [2:0] ALU2_MULH   = 3'd1;
    localparam logic [2:0] ALU2_MULHSU = 3'd2;
    localparam logic [2:0] ALU2_MULHU  = 3'd3;
    localparam logic [2:0] ALU2_DIV    = 3'd4;
    localparam logic [2:0] ALU2_DIVU   = 3'd5;
    localparam logic [2:0] ALU2_REM    = 3'd6;
    localparam logic [2:0] ALU2_REMU   = 3'd7;

    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_LINK = 2'd1;
    localparam logic [1:0] WB_ALU  = 2'd2;
    localparam logic [1:0] WB_ALU2 = 2'd3;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] rd;
        logic [2:0] alu_op;
        logic [2:0] alu2_op;
        logic       alt_op;
        logic       sel_pc_a;
        logic       sel_imm_b;
        logic [1:0] wb;
        logic       mem;
        logic       mem_read;
        logic       branch;
        logic       uncond;
        logic       eq_cmp;
        logic       inv_cmp;
        logic       mul;
    } decode_ctrl_t;

    localparam int CTRL_W = $bits(decode_ctrl_t);

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I (+optional M) instruction decoder.
// Ports:
//  instr   in  32    raw instruction
//  imm     out XLEN  sign-extended immediate, 0 for R-type / unknown formats
//  ctrl    out       decode_ctrl_t control bundle
//  illegal out 1     instruction is not in the supported set
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit HAS_M = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output decode_ctrl_t    ctrl,
    output logic            illegal
);

    logic [6:0]   opcode_s;
    logic [2:0]   funct3_s;
    logic [6:0]   funct7_s;
    logic [6:0]   shift_f7_s;
    imm_fmt_e     fmt_s;
    logic         use_rs1_s;
    logic         use_rs2_s;
    logic         use_rd_s;
    logic [1:0]   wb_s;
    logic         bad_op_s;
    logic         illegal_s;
    decode_ctrl_t base_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    // RV64 shift amounts are 6 bits wide, so instr[25] belongs to shamt there.
    assign shift_f7_s = {instr[31:26], (XLEN == 64) ? 1'b0 : instr[25]};

    // Opcode/funct decode into raw control fields and legality of the encoding.
    always_comb begin
        base_s    = '0;
        fmt_s     = IMM_NONE;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        wb_s      = WB_NONE;
        bad_op_s  = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                fmt_s            = IMM_U;
                use_rd_s         = 1'b1;
                base_s.sel_imm_b = 1'b1;
                wb_s             = WB_ALU;
            end
            OPC_AUIPC: begin
                fmt_s            = IMM_U;
                use_rd_s         = 1'b1;
                base_s.sel_pc_a  = 1'b1;
                base_s.sel_imm_b = 1'b1;
                wb_s             = WB_ALU;
            end
            OPC_JAL: begin
                fmt_s            = IMM_J;
                use_rd_s         = 1'b1;
                base_s.sel_pc_a  = 1'b1;
                base_s.sel_imm_b = 1'b1;
                base_s.branch    = 1'b1;
                base_s.uncond    = 1'b1;
                wb_s             = WB_LINK;
            end
            OPC_JALR: begin
                fmt_s            = IMM_I;
                use_rs1_s        = 1'b1;
                use_rd_s         = 1'b1;
                base_s.sel_imm_b = 1'b1;
                base_s.branch    = 1'b1;
                base_s.uncond    = 1'b1;
                wb_s             = WB_LINK;
            end
            OPC_BRANCH: begin
                fmt_s          = IMM_B;
                use_rs1_s      = 1'b1;
                use_rs2_s      = 1'b1;
                base_s.branch  = 1'b1;
                // BEQ/BNE compare via subtract, the ordered compares via SLT/SLTU.
                base_s.eq_cmp  = ~funct3_s[2];
                base_s.inv_cmp = funct3_s[0];
                base_s.alt_op  = ~funct3_s[2];
                base_s.alu_op  = funct3_s[2] ? (funct3_s[1] ? ALU_SLTU : ALU_SLT) : ALU_ADD;
            end
            OPC_LOAD: begin
                fmt_s            = IMM_I;
                use_rs1_s        = 1'b1;
                use_rd_s         = 1'b1;
                base_s.sel_imm_b = 1'b1;
                base_s.mem       = 1'b1;
                base_s.mem_read  = 1'b1;
                wb_s             = WB_ALU;
            end
            OPC_STORE: begin
                fmt_s            = IMM_S;
                use_rs1_s        = 1'b1;
                use_rs2_s        = 1'b1;
                base_s.sel_imm_b = 1'b1;
                base_s.mem       = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt_s            = IMM_I;
                use_rs1_s        = 1'b1;
                use_rd_s         = 1'b1;
                base_s.sel_imm_b = 1'b1;
                base_s.alu_op    = funct3_s;
                wb_s             = WB_ALU;
                case (funct3_s)
                    ALU_SLL: bad_op_s = (shift_f7_s != F7_BASE);
                    ALU_SR: begin
                        base_s.alt_op = instr[30];
                        bad_op_s      = (shift_f7_s != F7_BASE) && (shift_f7_s != F7_ALT);
                    end
                    default: bad_op_s = 1'b0;
                endcase
            end
            OPC_OP: begin
                use_rs1_s     = 1'b1;
                use_rs2_s     = 1'b1;
                use_rd_s      = 1'b1;
                base_s.alu_op = funct3_s;
                wb_s          = WB_ALU;
                case (funct7_s)
                    F7_BASE: bad_op_s = 1'b0;
                    F7_ALT: begin
                        base_s.alt_op = 1'b1;
                        bad_op_s      = (funct3_s != ALU_ADD) && (funct3_s != ALU_SR);
                    end
                    F7_MULDIV: begin
                        base_s.alu2_op = funct3_s;
                        base_s.mul     = HAS_M;
                        wb_s           = WB_ALU2;
                        bad_op_s       = ~HAS_M;
                    end
                    default: bad_op_s = 1'b1;
                endcase
            end
            default: bad_op_s = 1'b1;
        endcase
    end

    assign illegal_s = bad_op_s | (instr[1:0] != 2'b11);

    // Final control: register fields gated by usage, side effects suppressed when illegal.
    always_comb begin
        ctrl          = base_s;
        ctrl.ra       = use_rs1_s ? instr[19:15] : 5'd0;
        ctrl.rb       = use_rs2_s ? instr[24:20] : 5'd0;
        ctrl.rd       = use_rd_s  ? instr[11:7]  : 5'd0;
        ctrl.wb       = (illegal_s || (instr[11:7] == 5'd0)) ? WB_NONE : wb_s;
        ctrl.mem      = base_s.mem      & ~illegal_s;
        ctrl.mem_read = base_s.mem_read & ~illegal_s;
        ctrl.branch   = base_s.branch   & ~illegal_s;
        ctrl.uncond   = base_s.uncond   & ~illegal_s;
        ctrl.mul      = base_s.mul      & ~illegal_s;
    end

    assign illegal = illegal_s;

    // Immediate assembly, sign bit instr[31] replicated up to XLEN.
    always_comb begin
        case (fmt_s)
            IMM_I:   imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
            IMM_S:   imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
            IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
            IMM_J:   imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes {pc, instr} on the fetch handshake and queues the
// result in a DEPTH-entry in-order FIFO drained by execute.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  in_valid/in_ready     fetch handshake; in_ready depends only on registered state
//  in_instr, in_pc       instruction and its address
//  flush                 drop all queued entries and the input offered this cycle
//  out_valid/out_ready   execute handshake on the queue head
//  out_pc, out_imm       head pc and immediate
//  out_ctrl, out_illegal head control bundle and illegal flag
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter bit HAS_M = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        decode_ctrl_t    ctrl;
        logic            illegal;
    } entry_t;

    // Explicit wrap so non-power-of-two pointer ranges (DEPTH=1) stay in bounds.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [XLEN-1:0] dec_imm_s;
    decode_ctrl_t    dec_ctrl_s;
    logic            dec_illegal_s;
    entry_t          mem_r [DEPTH];
    entry_t          head_s;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             push_s;
    logic             pop_s;

    decode_comb #(
        .XLEN  (XLEN),
        .HAS_M (HAS_M)
    ) u_decode_comb (
        .instr   (in_instr),
        .imm     (dec_imm_s),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s)
    );

    assign push_s = in_valid & in_ready_r & ~flush;
    assign pop_s  = out_valid_r & out_ready;

    // Occupancy after this edge; flush empties the queue regardless of handshakes.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointers, count and the registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != CNT_W'(0));
            in_ready_r  <= (count_nxt_s != CNT_W'(DEPTH));
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
                rd_ptr_r <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            end
        end
    end

    // Queue storage: zeroed on reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= '{pc: in_pc, imm: dec_imm_s, ctrl: dec_ctrl_s, illegal: dec_illegal_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = head_s.pc;
    assign out_imm     = head_s.imm;
    assign out_ctrl    = head_s.ctrl;
    assign out_illegal = head_s.illegal;

endmodule
